// File: rtl/lsu_mem_seq.sv
// Load/store sequencer between the MEM stage and a byte-wide external RAM.
// Loads are served from the data cache on a hit. On a miss the bytes are
// fetched serially from RAM and the cache is filled. Stores are write-through.
module lsu_mem_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        req_i,
  input  logic        we_req_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic [31:0] dc_raddr_o,
  output logic [1:0]  dc_rbyte_o,
  input  logic        dc_hit_i,
  input  logic [31:0] dc_data_i,
  output logic        dc_we_o,
  output logic [1:0]  dc_wbyte_o,
  output logic [31:0] dc_waddr_o,
  output logic [31:0] dc_wdata_o,
  input  logic        mem_gnt_i,
  output logic [31:0] mem_a_o,
  output logic        mem_wr_o,
  output logic [7:0]  mem_dout_o,
  input  logic [7:0]  mem_din_i
);

  typedef enum logic [1:0] {StIdle, StCheck, StRead, StWrite} state_e;

  state_e      r_state, w_state_nx;
  logic [31:0] r_addr, r_wdata, r_buf;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [2:0]  r_iss, r_rcv;
  logic        r_pend;
  logic        r_done, r_dc_we;
  logic [31:0] r_rdata, r_dc_waddr, r_dc_wdata;
  logic [1:0]  r_dc_wbyte;

  logic [2:0]  w_n, w_rcv_nx;
  logic        w_issue, w_write, w_hit_fin, w_rd_fin, w_wr_fin;
  logic [31:0] w_buf_nx;
  logic [7:0]  w_wbyte;

  // Sign/zero extension of the low 1/2 bytes; words pass through.
  function automatic logic [31:0] f_ext(input logic [31:0] v, input logic [1:0] sz,
                                        input logic sg);
    logic [31:0] res;
    case (sz)
      2'b00:   res = {{24{sg & v[7]}}, v[7:0]};
      2'b01:   res = {{16{sg & v[15]}}, v[15:0]};
      default: res = v;
    endcase
    return res;
  endfunction

  // Keep only the bytes belonging to the access size.
  function automatic logic [31:0] f_mask(input logic [31:0] v, input logic [1:0] sz);
    logic [31:0] res;
    case (sz)
      2'b00:   res = {24'd0, v[7:0]};
      2'b01:   res = {16'd0, v[15:0]};
      default: res = v;
    endcase
    return res;
  endfunction

  assign w_n       = (r_size == 2'b00) ? 3'd1 : (r_size == 2'b01) ? 3'd2 : 3'd4;
  assign w_issue   = (r_state == StRead) && mem_gnt_i && rdy && (r_iss < w_n);
  assign w_write   = (r_state == StWrite) && mem_gnt_i && rdy;
  assign w_rcv_nx  = r_rcv + {2'd0, r_pend};
  assign w_hit_fin = (r_state == StCheck) && rdy && dc_hit_i;
  // Completion waits for rdy; a capture landing while paused is still taken.
  assign w_rd_fin  = (r_state == StRead) && rdy && (w_rcv_nx == w_n);
  assign w_wr_fin  = w_write && (r_iss == w_n - 3'd1);

  assign busy_o     = (r_state != StIdle);
  assign done_o     = r_done;
  assign rdata_o    = r_rdata;
  assign dc_raddr_o = (r_state == StCheck) ? r_addr : 32'd0;
  assign dc_rbyte_o = (r_state == StCheck) ? r_size : 2'd0;
  assign dc_we_o    = r_dc_we;
  assign dc_wbyte_o = r_dc_wbyte;
  assign dc_waddr_o = r_dc_waddr;
  assign dc_wdata_o = r_dc_wdata;

  // Merge the byte returning from RAM into its lane; bytes arrive in order.
  always_comb begin
    w_buf_nx = r_buf;
    if (r_pend) begin
      case (r_rcv[1:0])
        2'd0:    w_buf_nx[7:0]   = mem_din_i;
        2'd1:    w_buf_nx[15:8]  = mem_din_i;
        2'd2:    w_buf_nx[23:16] = mem_din_i;
        default: w_buf_nx[31:24] = mem_din_i;
      endcase
    end
  end

  // RAM port drive: address/data only in cycles that actually issue.
  always_comb begin
    mem_a_o    = 32'd0;
    mem_wr_o   = 1'b0;
    mem_dout_o = 8'd0;
    case (r_iss[1:0])
      2'd0:    w_wbyte = r_wdata[7:0];
      2'd1:    w_wbyte = r_wdata[15:8];
      2'd2:    w_wbyte = r_wdata[23:16];
      default: w_wbyte = r_wdata[31:24];
    endcase
    if (w_issue || w_write) mem_a_o = r_addr + {29'd0, r_iss};
    if (w_write) begin
      mem_wr_o   = 1'b1;
      mem_dout_o = w_wbyte;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      StIdle:  if (req_i && rdy) w_state_nx = we_req_i ? StWrite : StCheck;
      StCheck: if (rdy) w_state_nx = dc_hit_i ? StIdle : StRead;
      StRead:  if (w_rd_fin) w_state_nx = StIdle;
      StWrite: if (w_wr_fin) w_state_nx = StIdle;
      default: w_state_nx = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_nx;
  end

  // Request latch, byte counters, capture buffer and registered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_buf      <= 32'd0;
      r_size     <= 2'd0;
      r_signed   <= 1'b0;
      r_iss      <= 3'd0;
      r_rcv      <= 3'd0;
      r_pend     <= 1'b0;
      r_done     <= 1'b0;
      r_dc_we    <= 1'b0;
      r_rdata    <= 32'd0;
      r_dc_wbyte <= 2'd0;
      r_dc_waddr <= 32'd0;
      r_dc_wdata <= 32'd0;
    end else begin
      r_done  <= w_hit_fin | w_rd_fin | w_wr_fin;
      r_dc_we <= w_rd_fin | w_wr_fin;
      case (r_state)
        StIdle: begin
          if (req_i && rdy) begin
            r_addr   <= addr_i;
            r_wdata  <= wdata_i;
            r_size   <= (size_i == 2'b11) ? 2'b10 : size_i;
            r_signed <= signed_i;
            r_iss    <= 3'd0;
            r_rcv    <= 3'd0;
            r_pend   <= 1'b0;
            r_buf    <= 32'd0;
          end
        end
        StCheck: begin
          if (w_hit_fin) r_rdata <= f_ext(dc_data_i, r_size, r_signed);
        end
        StRead: begin
          r_pend <= w_issue;
          if (w_issue) r_iss <= r_iss + 3'd1;
          if (r_pend) begin
            r_rcv <= w_rcv_nx;
            r_buf <= w_buf_nx;
          end
          if (w_rd_fin) begin
            r_rdata    <= f_ext(w_buf_nx, r_size, r_signed);
            r_dc_wbyte <= r_size;
            r_dc_waddr <= r_addr;
            r_dc_wdata <= f_mask(w_buf_nx, r_size);
          end
        end
        StWrite: begin
          if (w_write) r_iss <= r_iss + 3'd1;
          if (w_wr_fin) begin
            r_dc_wbyte <= r_size;
            r_dc_waddr <= r_addr;
            r_dc_wdata <= f_mask(r_wdata, r_size);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/lsu_mem_seq.md
# lsu_mem_seq

Load/store memory sequencer between the MEM pipeline stage and the byte-wide external RAM bus. It serves loads from the data cache on a hit. On a miss it fetches the 1, 2 or 4 bytes serially from RAM and fills the data cache. Stores are write-through: bytes go serially to RAM, then the cache is updated. It drives the data cache's read and write ports directly and shares the RAM port with instruction fetch through a grant signal.

## Interface
- No parameters; address 32 bits, RAM data 8 bits.
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rdy  in  1  global run enable; low = pause
- req_i  in  1  request strobe, sampled only in IDLE
- we_req_i  in  1  1 = store, 0 = load
- size_i  in  2  00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes; 11 treated as 10
- signed_i  in  1  sign-extend loaded byte/half
- addr_i  in  32  byte address; no alignment requirement
- wdata_i  in  32  store data, little-endian
- busy_o  out  1  request in progress
- done_o  out  1  one-cycle completion pulse
- rdata_o  out  32  load result; valid while done_o is high, held afterwards
- dc_raddr_o / dc_rbyte_o  out  32 / 2  data cache read address and size
- dc_hit_i / dc_data_i  in  1 / 32  data cache hit flag and raw data (combinational)
- dc_we_o  out  1  data cache write strobe
- dc_wbyte_o / dc_waddr_o / dc_wdata_o  out  2 / 32 / 32  data cache write size, address and raw data
- mem_gnt_i  in  1  RAM port granted this cycle
- mem_a_o  out  32  RAM byte address
- mem_wr_o  out  1  RAM write strobe
- mem_dout_o  out  8  RAM write byte
- mem_din_i  in  8  RAM read byte; valid the cycle after its address

## Operation
- States: IDLE, CHECK, READ, WRITE.
- IDLE: if req_i && rdy, latch addr, size, signed, we and wdata. Next state is WRITE for a store, CHECK for a load.
- CHECK: drive dc_raddr_o and dc_rbyte_o from the latched request.
  - On dc_hit_i: register the extended dc_data_i into rdata_o, pulse done_o, go to IDLE.
  - Otherwise go to READ.
- READ: n = 1, 2 or 4 bytes. Keep an issue counter and a receive counter.
  - Issue byte k at mem_a_o = addr + k (mod 2^32) in every cycle where mem_gnt_i && rdy && issue < n, then increment issue.
  - A byte issued in cycle t is captured from mem_din_i at t+1 into lane k, regardless of grant or rdy at t+1.
  - After the last capture: rdata_o = extended value, done_o pulse, dc_we_o pulse with the raw zero-extended value and the latched size/address. Then go to IDLE.
- WRITE: in every granted cycle with rdy high, assert mem_wr_o with mem_a_o = addr + k and mem_dout_o = wdata byte k.
  - After byte n-1 is written: done_o pulse, and dc_we_o pulse with wdata masked to n bytes. Then go to IDLE.
- Extension applies when signed_i = 1: size 00 extends bit 7, size 01 extends bit 15. Unsigned loads zero-extend. 4-byte loads are unchanged.
- busy_o is high in CHECK, READ and WRITE.
- When rdy is low:
  - No issue; mem_wr_o = 0.
  - In-flight captures still complete.
  - done_o and dc_we_o pulses are deferred to the first cycle with rdy high.
- Idle outputs: mem_a_o = 0, mem_wr_o = 0, dc_we_o = 0.

## Timing
- Reset (async, rst_n low): state IDLE, counters 0. All outputs 0, including rdata_o, busy_o and done_o.
- Reset mid-operation abandons the request. No dc_we_o is issued and there is no further RAM access.
- Latencies with constant grant (request accepted at cycle c0):
  - Load hit: done_o at c2.
  - Load miss, n bytes: issues at c2..c(n+1), last capture c(n+2), done_o at c(n+3). For 4 bytes that is c7; for 1 byte, c4.
  - Store, n bytes: writes at c1..cn, done_o at c(n+1). For 4 bytes that is c5.
- done_o and dc_we_o are registered and coincide. State is IDLE in the done_o cycle, so a new request can be accepted in that same cycle.
- Each cycle mem_gnt_i is low adds one cycle. Bytes are never skipped or duplicated.
- req_i outside IDLE is ignored.
- Address wrap: addr 0xFFFFFFFF with size 01 accesses 0xFFFFFFFF, then 0x00000000.

## Test plan
- Load-hit path: preload the cache model with 0x80 at 0x100. Issue signed LB at 0x100 -> done_o at c2, rdata_o = 0xFFFFFF80, no RAM access.
- 4-byte load miss: RAM bytes 0x11, 0x22, 0x33, 0x44 at 0x200..0x203, grant constant -> mem_a_o sequence 0x200..0x203, rdata_o = 0x44332211, done_o at c7. Also dc_we_o with dc_wbyte_o = 10, dc_waddr_o = 0x200.
- Store SH of 0xBEEF to 0x301 -> mem_wr_o on 2 cycles with (0x301, 0xEF) then (0x302, 0xBE). done_o and dc_we_o with dc_wdata_o = 0x0000BEEF.
- Grant stall: 4-byte load miss with mem_gnt_i low for 3 cycles after the first issue -> correct data, done_o at c10.
- rdy low mid-READ for 2 cycles -> no issue while low, in-flight byte kept, done_o deferred, result correct.
- rst_n pulsed low during WRITE after 1 byte -> all outputs 0 immediately, no dc_we_o. The next request completes normally.
